// File: rtl/ysyx_23060059_ifu_pfq.sv
// Instruction fetch unit with a small prefetch queue.
// Issues one AR request at a time to the icache and buffers {pc, instruction}
// pairs for the IDU. A redirect flushes the queue and marks the outstanding
// request stale so that its response is thrown away.
// Optional macro YSYX_23060059_IFU_PERF_EN adds fetch/drop performance counters.
module ysyx_23060059_ifu_pfq #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  output logic              send_valid,
  input  logic              receive_ready,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] pc_ifu_to_idu
`ifdef YSYX_23060059_IFU_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_drop_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q;
  logic              inflight_q, inflight_d;
  logic              stale_q, stale_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [DATA_W-1:0] inst_mem_q [DEPTH];

  logic ar_hs, r_hs, push, pop;

  // Handshake qualifiers; a redirect suppresses both push and pop.
  always_comb begin
    ar_hs = arvalid_q && arready;
    r_hs  = rvalid && rready_q && inflight_q;
    push  = r_hs && !stale_q && !redirect_valid;
    pop   = (count_q != '0) && receive_ready && !redirect_valid;
  end

  // Next-state for fetch pointer, request channel, flags and queue pointers.
  // stale marks the outstanding request (pending or in flight) as belonging to
  // a flushed path; it is cleared when that request's response completes, so a
  // redirect seen while AR is still pending survives the AR handshake.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    araddr_d   = araddr_q;
    arvalid_d  = arvalid_q;
    inflight_d = inflight_q;
    stale_d    = stale_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    if (ar_hs) begin
      inflight_d = 1'b1;
      arvalid_d  = 1'b0;
      if (!stale_q) fetch_pc_d = araddr_q + ADDR_W'(4);
    end
    if (r_hs) begin
      inflight_d = 1'b0;
      stale_d    = 1'b0;
    end

    if (push) tail_d = tail_q + PTR_W'(1);
    if (pop)  head_d = head_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (redirect_valid) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = redirect_pc;
      stale_d    = (inflight_q && !r_hs) || arvalid_q;
    end

    if (!arvalid_q && !inflight_d && (count_d < CNT_W'(DEPTH))) begin
      arvalid_d = 1'b1;
      araddr_d  = fetch_pc_d;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      araddr_q   <= RESET_PC;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      inflight_q <= 1'b0;
      stale_q    <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      araddr_q   <= araddr_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= 1'b1;
      inflight_q <= inflight_d;
      stale_q    <= stale_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Queue storage; cleared on reset so the head outputs read zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[tail_q]   <= araddr_q;
      inst_mem_q[tail_q] <= rdata;
    end
  end

`ifdef YSYX_23060059_IFU_PERF_EN
  logic [31:0] perf_fetch_q, perf_drop_q;

  // Count pushed responses, and dropped responses plus entries flushed by redirect.
  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_fetch_q <= '0;
      perf_drop_q  <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_q + 32'(push);
      perf_drop_q  <= perf_drop_q + 32'(r_hs && !push)
                      + (redirect_valid ? 32'(count_q) : 32'd0);
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_drop_cnt  = perf_drop_q;
`endif

  assign arvalid       = arvalid_q;
  assign araddr        = araddr_q;
  assign rready        = rready_q;
  assign send_valid    = (count_q != '0);
  assign instruction   = inst_mem_q[head_q];
  assign pc_ifu_to_idu = pc_mem_q[head_q];

endmodule

// File: tb/tb_ysyx_23060059_ifu_pfq.sv
// Directed bench for the IFU prefetch queue (default build, DEPTH = 4).
module tb_ysyx_23060059_ifu_pfq;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic        send_valid;
  logic        receive_ready;
  logic [31:0] instruction;
  logic [31:0] pc_ifu_to_idu;

  int checks = 0;
  int errors = 0;
  int ar_hs_cnt = 0;
  int hs_base;

  ysyx_23060059_ifu_pfq dut (
    .clock         (clock),
    .reset         (reset),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .arvalid       (arvalid),
    .arready       (arready),
    .araddr        (araddr),
    .rvalid        (rvalid),
    .rready        (rready),
    .rdata         (rdata),
    .send_valid    (send_valid),
    .receive_ready (receive_ready),
    .instruction   (instruction),
    .pc_ifu_to_idu (pc_ifu_to_idu)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset && arvalid && arready) ar_hs_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    arready        = 1'b0;
    rvalid         = 1'b0;
    rdata          = '0;
    receive_ready  = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    logic [31:0] exp_pc;

    // Reset values
    do_reset();
    reset = 1'b0;
    step();
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_araddr", 64'(araddr), 64'h8000_0000);
    chk("rst_send_valid", 64'(send_valid), 64'd0);
    chk("rst_instruction", 64'(instruction), 64'd0);
    chk("rst_pc", 64'(pc_ifu_to_idu), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    reset = 1'b1;
    step();
    chk("first_arvalid", 64'(arvalid), 64'd1);
    chk("first_araddr", 64'(araddr), 64'h8000_0000);
    chk("first_rready", 64'(rready), 64'd1);

    // Streaming fetch with a consumer that is always ready
    arready       = 1'b1;
    receive_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_pc = 32'h8000_0000 + 32'(4 * k);
      step();
      chk("stream_ar_low", 64'(arvalid), 64'd0);
      chk("stream_empty", 64'(send_valid), 64'd0);
      rvalid = 1'b1;
      rdata  = 32'h1000 + 32'(k);
      step();
      rvalid = 1'b0;
      chk("stream_send_valid", 64'(send_valid), 64'd1);
      chk("stream_instr", 64'(instruction), 64'(32'h1000 + 32'(k)));
      chk("stream_pc", 64'(pc_ifu_to_idu), 64'(exp_pc));
      chk("stream_arvalid", 64'(arvalid), 64'd1);
      chk("stream_araddr", 64'(araddr), 64'(exp_pc + 32'd4));
    end

    // Fill the queue with a stalled consumer, then release one entry
    do_reset();
    arready = 1'b1;
    hs_base = ar_hs_cnt;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("fill_ar_low", 64'(arvalid), 64'd0);
      rvalid = 1'b1;
      rdata  = 32'h2000 + 32'(k);
      step();
      rvalid = 1'b0;
      chk("fill_arvalid", 64'(arvalid), (k < 3) ? 64'd1 : 64'd0);
    end
    step();
    step();
    step();
    chk("full_arvalid", 64'(arvalid), 64'd0);
    chk("full_ar_count", 64'(ar_hs_cnt - hs_base), 64'd4);
    chk("full_instr", 64'(instruction), 64'h2000);
    chk("full_pc", 64'(pc_ifu_to_idu), 64'h8000_0000);
    receive_ready = 1'b1;
    step();
    receive_ready = 1'b0;
    chk("pop_arvalid", 64'(arvalid), 64'd1);
    chk("pop_araddr", 64'(araddr), 64'h8000_0010);
    chk("pop_instr", 64'(instruction), 64'h2001);
    chk("pop_pc", 64'(pc_ifu_to_idu), 64'h8000_0004);

    // Redirect while a response is in flight and two entries are queued
    do_reset();
    arready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      rvalid = 1'b1;
      rdata  = 32'h2800 + 32'(k);
      step();
      rvalid = 1'b0;
    end
    chk("rd1_araddr_pre", 64'(araddr), 64'h8000_0008);
    step();
    chk("rd1_inflight_ar", 64'(arvalid), 64'd0);
    chk("rd1_queued", 64'(send_valid), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_1000;
    step();
    redirect_valid = 1'b0;
    chk("rd1_flushed", 64'(send_valid), 64'd0);
    chk("rd1_ar_wait", 64'(arvalid), 64'd0);
    rvalid = 1'b1;
    rdata  = 32'hdead_0008;
    step();
    rvalid = 1'b0;
    chk("rd1_dropped", 64'(send_valid), 64'd0);
    chk("rd1_arvalid", 64'(arvalid), 64'd1);
    chk("rd1_araddr", 64'(araddr), 64'h8000_1000);
    step();
    rvalid = 1'b1;
    rdata  = 32'h3000;
    step();
    rvalid = 1'b0;
    chk("rd1_new_valid", 64'(send_valid), 64'd1);
    chk("rd1_new_instr", 64'(instruction), 64'h3000);
    chk("rd1_new_pc", 64'(pc_ifu_to_idu), 64'h8000_1000);

    // Redirect while AR is pending and stalled by arready
    do_reset();
    step();
    chk("rd2_hold_v", 64'(arvalid), 64'd1);
    chk("rd2_hold_a", 64'(araddr), 64'h8000_0000);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_2000;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    chk("rd2_keep_v", 64'(arvalid), 64'd1);
    chk("rd2_keep_a", 64'(araddr), 64'h8000_0000);
    arready = 1'b1;
    step();
    chk("rd2_hs", 64'(arvalid), 64'd0);
    rvalid = 1'b1;
    rdata  = 32'hbad0_0000;
    step();
    rvalid = 1'b0;
    chk("rd2_dropped", 64'(send_valid), 64'd0);
    chk("rd2_arvalid", 64'(arvalid), 64'd1);
    chk("rd2_araddr", 64'(araddr), 64'h8000_2000);
    step();
    rvalid = 1'b1;
    rdata  = 32'h4000;
    step();
    rvalid = 1'b0;
    chk("rd2_new_instr", 64'(instruction), 64'h4000);
    chk("rd2_new_pc", 64'(pc_ifu_to_idu), 64'h8000_2000);

    // Redirect coincident with a pop, then a second redirect that must win
    arready        = 1'b0;
    receive_ready  = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_3000;
    step();
    receive_ready = 1'b0;
    chk("rd3_no_xfer", 64'(send_valid), 64'd0);
    chk("rd3_old_addr", 64'(araddr), 64'h8000_2004);
    redirect_pc = 32'h8000_3100;
    step();
    redirect_valid = 1'b0;
    chk("rd3_pending", 64'(arvalid), 64'd1);
    arready = 1'b1;
    step();
    rvalid = 1'b1;
    rdata  = 32'hbad0_2004;
    step();
    rvalid = 1'b0;
    chk("rd3_dropped", 64'(send_valid), 64'd0);
    chk("rd3_last_wins", 64'(araddr), 64'h8000_3100);

    // Reset in the middle of an outstanding request
    do_reset();
    arready = 1'b1;
    step();
    chk("mid_inflight", 64'(arvalid), 64'd0);
    reset = 1'b0;
    step();
    step();
    chk("mid_rst_arvalid", 64'(arvalid), 64'd0);
    chk("mid_rst_rready", 64'(rready), 64'd0);
    reset  = 1'b1;
    rvalid = 1'b1;
    rdata  = 32'hbeef_0000;
    step();
    chk("mid_ignored", 64'(send_valid), 64'd0);
    chk("mid_first_v", 64'(arvalid), 64'd1);
    chk("mid_first_a", 64'(araddr), 64'h8000_0000);
    step();
    rvalid = 1'b0;
    chk("mid_still_empty", 64'(send_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
